board_io_conditioner: RTL and testbench

Board-level conditioning block placed between FPGA pins/clock wizard and the functional core in the board top. It turns the clock wizard `locked` flag and the external reset into a clean core reset. It debounces and synchronises N switch/button inputs with edge pulses, generates a shared timebase tick, and drives N status LEDs in off/on/slow-blink/fast-blink modes.

---
 rtl/board_io_conditioner.sv | 173 +++++++++++++++++
 tb/tb_board_io_conditioner.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/board_io_conditioner.sv
// Board-level conditioning: lock-qualified core reset, debounced inputs
// with edge pulses, shared timebase tick and blinking status LEDs.
module board_io_conditioner #(
  parameter int N_IN        = 2,
  parameter int N_LED       = 1,
  parameter int DEB_CYCLES  = 50000,
  parameter int TICK_DIV    = 5000,
  parameter int LOCK_HOLD   = 1024,
  parameter int BLINK_TICKS = 250
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               locked,
  input  logic [N_IN-1:0]    raw_in,
  input  logic [2*N_LED-1:0] led_mode,
  output logic               rst_out,
  output logic               tick,
  output logic [N_IN-1:0]    in_level,
  output logic [N_IN-1:0]    in_rise,
  output logic [N_IN-1:0]    in_fall,
  output logic [N_LED-1:0]   led_out
);

  localparam int FQ = BLINK_TICKS / 4;
  localparam int HW = $clog2(LOCK_HOLD + 1);
  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_CYCLES);
  localparam int SW = $clog2(BLINK_TICKS);
  localparam int FW = (FQ > 1) ? $clog2(FQ) : 1;

  logic          lk_m;
  logic          lk_s;
  logic [HW-1:0] hcnt;
  logic          hold;

  // A falling lk_s already blocks this edge, so reset beats a
  // debounce completing in the same cycle.
  assign hold = rst_out | ~lk_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lk_m    <= 1'b0;
      lk_s    <= 1'b0;
      hcnt    <= '0;
      rst_out <= 1'b1;
    end else begin
      lk_m <= locked;
      lk_s <= lk_m;
      if (!lk_s) begin
        hcnt    <= '0;
        rst_out <= 1'b1;
      end else begin
        if (hcnt != HW'(LOCK_HOLD))
          hcnt <= hcnt + 1'b1;
        rst_out <= (hcnt < HW'(LOCK_HOLD - 1));
      end
    end
  end

  logic [TW-1:0] tcnt;
  logic          twrap;

  assign twrap = (tcnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
      tick <= 1'b0;
    end else if (hold) begin
      tcnt <= '0;
      tick <= 1'b0;
    end else begin
      tick <= twrap;
      tcnt <= twrap ? '0 : tcnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_IN; i++) begin : g_deb
    logic          m;
    logic          s;
    logic          lvl;
    logic          rs;
    logic          fl;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        m   <= 1'b0;
        s   <= 1'b0;
        lvl <= 1'b0;
        rs  <= 1'b0;
        fl  <= 1'b0;
        cnt <= '0;
      end else if (hold) begin
        m   <= 1'b0;
        s   <= 1'b0;
        lvl <= 1'b0;
        rs  <= 1'b0;
        fl  <= 1'b0;
        cnt <= '0;
      end else begin
        m  <= raw_in[i];
        s  <= m;
        rs <= 1'b0;
        fl <= 1'b0;
        if (s == lvl) begin
          cnt <= '0;
        end else if (cnt == DW'(DEB_CYCLES - 1)) begin
          lvl <= s;
          cnt <= '0;
          rs  <= s;
          fl  <= ~s;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign in_level[i] = lvl;
    assign in_rise[i]  = rs;
    assign in_fall[i]  = fl;
  end

  logic [SW-1:0] scnt;
  logic [FW-1:0] fcnt;
  logic          slow;
  logic          fast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt <= '0;
      fcnt <= '0;
      slow <= 1'b0;
      fast <= 1'b0;
    end else if (hold) begin
      scnt <= '0;
      fcnt <= '0;
      slow <= 1'b0;
      fast <= 1'b0;
    end else if (tick) begin
      if (scnt == SW'(BLINK_TICKS - 1)) begin
        scnt <= '0;
        slow <= ~slow;
      end else begin
        scnt <= scnt + 1'b1;
      end
      if (fcnt == FW'(FQ - 1)) begin
        fcnt <= '0;
        fast <= ~fast;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_out <= '1;
    end else if (hold) begin
      led_out <= '1;
    end else begin
      for (int i = 0; i < N_LED; i++) begin
        unique case (led_mode[2*i +: 2])
          2'b00:   led_out[i] <= 1'b0;
          2'b01:   led_out[i] <= 1'b1;
          2'b10:   led_out[i] <= slow;
          default: led_out[i] <= fast;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_board_io_conditioner.sv
// Directed self-checking bench for board_io_conditioner with small
// parameters (hold 8, tick 5, debounce 4, blink 4).
module tb_board_io_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked;
  logic [1:0] raw_in;
  logic [1:0] led_mode;
  logic       rst_out;
  logic       tick;
  logic [1:0] in_level;
  logic [1:0] in_rise;
  logic [1:0] in_fall;
  logic [0:0] led_out;

  int checks   = 0;
  int failures = 0;
  int t        = 0;
  int first;
  int npulse;

  always #5 clk = ~clk;

  board_io_conditioner #(
    .N_IN(2), .N_LED(1), .DEB_CYCLES(4),
    .TICK_DIV(5), .LOCK_HOLD(8), .BLINK_TICKS(4)
  ) dut (
    .clk(clk), .rst(rst), .locked(locked),
    .raw_in(raw_in), .led_mode(led_mode),
    .rst_out(rst_out), .tick(tick),
    .in_level(in_level), .in_rise(in_rise),
    .in_fall(in_fall), .led_out(led_out)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      t++;
    end
    #1;
  endtask

  // Output after edge R+tt, where R is the edge rst_out fell:
  // fast toggles at R+6,11,..; slow at R+21,41,..; one register of delay.
  function automatic logic led_exp(input logic [1:0] m, input int tt);
    int  u;
    logic f;
    logic s;
    u = tt - 1;
    f = (((u - 1) / 5) % 2) != 0;
    s = (((u - 1) / 20) % 2) != 0;
    case (m)
      2'b00:   return 1'b0;
      2'b01:   return 1'b1;
      2'b10:   return s;
      default: return f;
    endcase
  endfunction

  task automatic led_step(input int n);
    repeat (n) begin
      step(1);
      chk($sformatf("led_m%0b_t%0d", led_mode, t),
          led_out, led_exp(led_mode, t));
    end
  endtask

  initial begin
    rst      = 1'b1;
    locked   = 1'b0;
    raw_in   = 2'b00;
    led_mode = 2'b00;
    #2;
    chk("rst_rst_out", rst_out, 1);
    chk("rst_tick", tick, 0);
    chk("rst_level", in_level, 0);
    chk("rst_rise", in_rise, 0);
    chk("rst_fall", in_fall, 0);
    chk("rst_led", led_out, 1);

    @(posedge clk);
    #1 rst = 1'b0;
    step(5);
    locked = 1'b1;
    step(9);
    chk("lock_edge9", rst_out, 1);
    step(1);
    chk("lock_edge10", rst_out, 0);
    t = 0;

    first  = 0;
    npulse = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (tick && first == 0) first = i;
      if (tick) npulse++;
    end
    chk("tick_first", first, 5);
    chk("tick_count20", npulse, 4);

    led_mode = 2'b00;
    led_step(2);
    led_mode = 2'b01;
    led_step(2);
    led_mode = 2'b10;
    led_step(45);
    led_mode = 2'b11;
    led_step(12);
    led_mode = 2'b10;
    led_step(7);
    led_mode = 2'b11;
    led_step(3);
    led_mode = 2'b00;

    raw_in = 2'b01;
    step(3);
    raw_in = 2'b00;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("glitch_level", in_level, 0);
      chk("glitch_rise", in_rise, 0);
    end

    raw_in = 2'b01;
    step(5);
    chk("rise_early", in_level, 2'b00);
    step(1);
    chk("rise_level", in_level, 2'b01);
    chk("rise_pulse", in_rise, 2'b01);
    chk("rise_nofall", in_fall, 2'b00);
    step(1);
    chk("rise_single", in_rise, 2'b00);
    chk("rise_hold", in_level, 2'b01);

    raw_in = 2'b00;
    step(5);
    chk("fall_early", in_level, 2'b01);
    step(1);
    chk("fall_level", in_level, 2'b00);
    chk("fall_pulse", in_fall, 2'b01);
    step(1);
    chk("fall_single", in_fall, 2'b00);

    raw_in = 2'b10;
    step(6);
    chk("ch1_level", in_level, 2'b10);
    chk("ch1_rise", in_rise, 2'b10);
    step(1);
    chk("ch1_rise_end", in_rise, 2'b00);
    raw_in = 2'b00;
    step(6);
    chk("ch1_fall", in_fall, 2'b10);
    chk("ch1_level0", in_level, 2'b00);

    step(1);
    chk("led_before_drop", led_out, 0);
    locked = 1'b0;
    step(2);
    chk("drop_edge2", rst_out, 0);
    step(1);
    chk("drop_edge3", rst_out, 1);
    chk("drop_led", led_out, 1);

    locked = 1'b1;
    step(9);
    chk("relock_edge9", rst_out, 1);
    step(1);
    chk("relock_edge10", rst_out, 0);
    raw_in = 2'b01;
    step(6);
    chk("pre_async_level", in_level, 2'b01);
    step(2);
    chk("pre_async_led", led_out, 0);
    raw_in = 2'b00;
    step(3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", rst_out, 1);
    chk("async_level", in_level, 0);
    chk("async_fall", in_fall, 0);
    chk("async_tick", tick, 0);
    chk("async_led", led_out, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("post_rise", in_rise, 0);
      chk("post_fall", in_fall, 0);
      chk("post_level", in_level, 0);
    end
    chk("post_rst_out", rst_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
